softmax_row_scheduler: RTL

SOFTMAX_ROW_SCHEDULER -- requirements
Module: softmax_row_scheduler

---
 rtl/softmax_sched_pkg.sv | 20 ++
 rtl/softmax_row_scheduler_arbiter.sv | 40 ++++
 rtl/softmax_row_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/softmax_sched_pkg.sv
// -----------------------------------------------------------------------------
// softmax_sched_pkg
//   Shared types and constants for the softmax row scheduler.
//   - sched_state_t : scheduler FSM states
//   - CLR_CYCLES    : number of cycles the engine reset is held low per row
// -----------------------------------------------------------------------------
package softmax_sched_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLR     = 3'd1,
      FEED    = 3'd2,
      WAIT    = 3'd3,
      RADDR   = 3'd4,
      PRESENT = 3'd5
   } sched_state_t;

   localparam int CLR_CYCLES = 2;

endpackage

// File: rtl/softmax_row_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant. The search starts at requester `ptr`
//   and wraps; the first active request wins.
//   Ports:
//     req        in  NUM_REQ  request vector
//     ptr        in  IDW      highest-priority requester for this decision
//     en         in  1        grant enable (no grant when low)
//     grant_oh   out NUM_REQ  one-hot grant (all zero when nothing granted)
//     grant_idx  out IDW      encoded grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [IDW-1:0]     grant_idx
);

   always_comb begin
      int k;
      k         = 0;
      grant_oh  = '0;
      grant_idx = '0;
      if (en) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (req[k] && (grant_oh == '0)) begin
               grant_oh[k] = 1'b1;
               grant_idx   = IDW'(k);
            end
         end
      end
   end

endmodule

// File: rtl/softmax_row_scheduler.sv
// -----------------------------------------------------------------------------
// softmax_row_scheduler
//   Shares one softermax engine between NUM_REQ requesters, one full row at a
//   time. A row is granted round-robin, the engine is cleared, ROW_WIDTH
//   elements are streamed through, and once the engine reports completion the
//   result buffer is read back one word per two cycles.
//
//   Optional feature: define SOFTMAX_SCHED_TIMEOUT_EN to enable a watchdog on
//   the engine-completion wait (fires after TIMEOUT cycles, drops the row).
//
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     req_valid/ready/data   per-requester element stream (flattened data)
//     out_valid/ready/data   result word stream, out_id = row owner,
//                            out_last marks the final word of the row
//     eng_rst_n              engine reset (active low)
//     eng_input_valid/vector element strobe and value to the engine
//     eng_read_addr          engine result buffer address
//     eng_final_out_valid    engine row complete (sticky)
//     eng_prob               engine buffer data, one cycle after address
//     busy                   FSM not idle
//     timeout_err            watchdog pulse (0 without the macro)
// -----------------------------------------------------------------------------
module softmax_row_scheduler
   import softmax_sched_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_SIZE  = 8,
   parameter  int LARGE_SIZE = 16,
   parameter  int ROW_WIDTH  = 64,
   parameter  int TIMEOUT    = 1024,
   localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int AW         = $clog2(ROW_WIDTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LARGE_SIZE:0]            out_data,
   output logic [IDW-1:0]                 out_id,
   output logic                           out_last,
   output logic                           eng_rst_n,
   output logic                           eng_input_valid,
   output logic [DATA_SIZE-1:0]           eng_input_vector,
   output logic [AW-1:0]                  eng_read_addr,
   input  logic                           eng_final_out_valid,
   input  logic [LARGE_SIZE:0]            eng_prob,
   output logic                           busy,
   output logic                           timeout_err
);

   localparam int CW = AW + 1;

   if (ROW_WIDTH < 2 || (ROW_WIDTH & (ROW_WIDTH - 1)) != 0) begin : g_bad_row_width
      $error("softmax_row_scheduler: ROW_WIDTH must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("softmax_row_scheduler: TIMEOUT must be >= 1");
   end

   sched_state_t         state, next_state;
   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       grant_id;
   logic [NUM_REQ-1:0]   grant_oh_q;
   logic [IDW-1:0]       arb_idx;
   logic [NUM_REQ-1:0]   arb_oh;
   logic [1:0]           clr_cnt;
   logic [CW-1:0]        elem_cnt;
   logic [AW-1:0]        rd_idx;
   logic                 eng_en_q;
   logic                 pres_first;
   logic [LARGE_SIZE:0]  prob_q;
   logic                 accept;
   logic                 wd_fire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .en        (state == IDLE),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|req_valid) next_state = CLR;
         CLR:     if (clr_cnt == 2'(CLR_CYCLES - 1)) next_state = FEED;
         FEED:    if (accept && (elem_cnt == CW'(ROW_WIDTH - 1))) next_state = WAIT;
         WAIT: begin
            if (eng_final_out_valid) next_state = RADDR;
            else if (wd_fire)        next_state = IDLE;
         end
         RADDR:   next_state = PRESENT;
         PRESENT: if (out_ready) next_state = out_last ? IDLE : RADDR;
         default: next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready       = '0;
      accept          = 1'b0;
      eng_input_valid = 1'b0;
      out_valid       = 1'b0;
      out_last        = 1'b0;
      case (state)
         FEED: begin
            req_ready       = grant_oh_q;
            accept          = |(req_valid & grant_oh_q);
            eng_input_valid = accept;
         end
         PRESENT: begin
            out_valid = 1'b1;
            out_last  = (rd_idx == AW'(ROW_WIDTH - 1));
         end
         default: ;
      endcase
   end

   assign eng_input_vector = req_data[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
   assign eng_read_addr    = rd_idx;
   assign out_id           = grant_id;
   assign busy             = (state != IDLE);
   // eng_en_q keeps the engine in reset until the first edge after rst drops.
   assign eng_rst_n        = eng_en_q && (state != CLR);
   // The engine answers one cycle after RADDR, i.e. in the first PRESENT
   // cycle; forward it then and hold the captured copy until accepted.
   assign out_data         = pres_first ? eng_prob : prob_q;

   // Row control: grant, clear, element count, read index, result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         grant_id   <= '0;
         grant_oh_q <= '0;
         clr_cnt    <= '0;
         elem_cnt   <= '0;
         rd_idx     <= '0;
         eng_en_q   <= 1'b0;
         pres_first <= 1'b0;
         prob_q     <= '0;
      end else begin
         eng_en_q   <= 1'b1;
         pres_first <= (state == RADDR);
         if (pres_first) prob_q <= eng_prob;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant_id   <= arb_idx;
                  grant_oh_q <= arb_oh;
                  rr_ptr     <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
                  clr_cnt    <= '0;
                  elem_cnt   <= '0;
               end
            end
            CLR:     clr_cnt <= clr_cnt + 2'd1;
            FEED:    if (accept) elem_cnt <= elem_cnt + CW'(1);
            WAIT:    if (eng_final_out_valid) rd_idx <= '0;
            PRESENT: if (out_ready && !out_last) rd_idx <= rd_idx + AW'(1);
            default: ;
         endcase
      end
   end

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);

   logic [WDW-1:0] wd_cnt;
   logic           timeout_q;

   // Counter sits at 0 outside WAIT so each wait starts a fresh count.
   assign wd_fire = (state == WAIT) && !eng_final_out_valid &&
                    (wd_cnt == WDW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wd_fire;
         if (state == WAIT) wd_cnt <= wd_cnt + WDW'(1);
         else               wd_cnt <= '0;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
